led_arbiter: RTL and testbench
==============================

# led_arbiter

Shares the board RGB LED between up to NREQ on-chip status sources, with fair rotation and PWM brightness control. Clocked from the SB_HFOSC 48 MHz domain. Sits between the status producers (CPU, link, error logic) and the LED_R/LED_G/LED_B top-level pins. It replaces direct counter-bit LED drive.

## Interface
- NREQ, 4: number of requesters (2..8)
- PWM_W, 8: duty/PWM counter width
- MAX_HOLD, 16777216: max consecutive grant cycles while another requester waits (≥2)
- clk  in  1  system clock (HFOSC)
- rstn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester LED request, level-sensitive
- color  in  3*NREQ  per-requester {R,G,B} enable; requester i at [3i+2:3i]
- duty  in  PWM_W*NREQ  per-requester brightness; requester i at [PWM_W*(i+1)-1:PWM_W*i]
- gnt  out  NREQ  one-hot grant, registered
- busy  out  1  high while some requester owns the LED
- led_r, led_g, led_b  out  1  active-high LED drive, registered (pin inversion done at top level)

## Operation
- Reset: state IDLE, gnt=0, busy=0, led_*=0, hold_cnt=0, pwm_cnt=0, rr pointer last=NREQ-1 (requester 0 wins first).
- FSM states: IDLE, OWNED.
- IDLE: if req≠0, pick first set req scanning from (last+1) mod NREQ upward with wrap; next cycle gnt=onehot(winner), last=winner, hold_cnt=0, state OWNED. If req=0, stay.
- OWNED, release: owner's req low → next cycle gnt=0, state IDLE. last unchanged.
- OWNED, preemption: hold_cnt==MAX_HOLD-1 and any other req high → next cycle gnt=0, state IDLE. Owner rejoins rotation normally.
- OWNED, no contention: hold_cnt saturates at MAX_HOLD-1; owner keeps LED indefinitely.
- Release and preemption in same cycle: treated as release (same outcome).
- color/duty are read live from the owner every cycle (no latching), so owners may fade.
- PWM: pwm_cnt free-runs mod 2^PWM_W, independent of arbitration. Channel x on iff OWNED & color_owner[x] & (pwm_cnt < duty_owner). duty=0 → off; duty=2^PWM_W-1 → on 255/256 of period. In IDLE all LEDs are 0.
- busy = (state==OWNED), registered together with gnt.
- Requests for bits ≥NREQ do not exist. X on unowned requesters' color/duty must not propagate.

## Timing
- Grant latency: req rises at cycle 0 in IDLE → gnt/busy high at cycle 1.
- LED latency: led_* reflect owner and pwm_cnt compare one cycle after gnt, i.e. cycle 2.
- Release: owner req low at cycle t → gnt=0 at t+1, led_*=0 at t+2. The earliest next grant is t+2, giving one dead IDLE cycle minimum.
- Preemption: gnt high exactly MAX_HOLD cycles, low for ≥1 cycle, then the next requester in rotation is granted.
- PWM period 2^PWM_W cycles, 187.5 kHz at 48 MHz/8 bit.
- rstn assertion mid-operation: all outputs 0 asynchronously. Deassertion is synchronized externally. First grant ≥1 cycle after deassertion.

## Structure
- Package led_arb_pkg: state enum (IDLE, OWNED), localparam HOLD_W=$clog2(MAX_HOLD), COLOR_W=3, channel index constants R=2/G=1/B=0.
- Sub-module led_pwm: pwm_cnt plus 3-channel compare/register, ports clk, rstn, en, color[2:0], duty[PWM_W-1:0], led_r/g/b. The arbiter FSM, round-robin pointer and hold counter stay in the top.
- Round-robin pick as a function (rotate, priority-encode, un-rotate), no extra module.

## Test plan
Benches override MAX_HOLD=16, PWM_W=4.
- Reset then req=4'b0001, color0=3'b100, duty0=8 → gnt=0001 at cycle 1; led_r high exactly 8 of every 16 cycles; led_g=led_b=0.
- req=4'b1111 held constant → grants rotate 0,1,2,3,0. Each gnt high 16 cycles, then a 1-cycle gap.
- Owner 2 drops req at cycle t while req1 high → gnt=0 at t+1, gnt=0010 at t+2, LEDs 0 at t+2.
- Single requester held 100 cycles → gnt constant, no preemption gap; duty0=0 → LEDs stay 0, duty0=15 → on 15/16.
- rstn pulsed low mid-grant → gnt, busy, led_* 0 immediately. After release with req=4'b1000, requester 3 is granted (pointer reset).
- Owner changes duty from 2 to 12 mid-grant → duty cycle changes within one PWM period, gnt unaffected.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and constants for the RGB LED arbiter.
//   arb_state_t : arbiter FSM state (IDLE, OWNED)
//   COLOR_W     : number of colour channels per requester ({R,G,B})
//   CH_R/G/B    : bit index of each channel inside a colour field
//   HOLD_W      : hold-counter width for the default MAX_HOLD
package led_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int COLOR_W      = 3;
    localparam int CH_R         = 2;
    localparam int CH_G         = 1;
    localparam int CH_B         = 0;
    localparam int MAX_HOLD_DEF = 16777216;
    localparam int HOLD_W       = $clog2(MAX_HOLD_DEF);

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter plus a registered 3-channel compare stage.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   en         : channel outputs allowed (LED currently owned)
//   color[2:0] : {R,G,B} enables of the current owner
//   duty       : brightness of the current owner, on while counter < duty
//   led_r/g/b  : registered active-high LED drive
module led_pwm
    import led_arb_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [COLOR_W-1:0] color,
    input  logic [PWM_W-1:0]   duty,
    output logic               led_r,
    output logic               led_g,
    output logic               led_b
);

    logic [PWM_W-1:0] r_cnt;
    logic             r_led_r;
    logic             r_led_g;
    logic             r_led_b;
    logic             w_on;

    // Compare is strict so duty=0 never lights and full-scale duty lights all but one slot.
    assign w_on = en & (r_cnt < duty);

    // Counter wraps naturally at 2^PWM_W, independent of arbitration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered channel drive.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_led_r <= 1'b0;
            r_led_g <= 1'b0;
            r_led_b <= 1'b0;
        end else begin
            r_led_r <= w_on & color[CH_R];
            r_led_g <= w_on & color[CH_G];
            r_led_b <= w_on & color[CH_B];
        end
    end

    assign led_r = r_led_r;
    assign led_g = r_led_g;
    assign led_b = r_led_b;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing the board RGB LED between NREQ status sources,
// with a hold limit under contention and PWM brightness from the owner.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   req        : per-requester level request
//   color      : per-requester {R,G,B} enables, requester i at [3i+2:3i]
//   duty       : per-requester brightness, requester i at [PWM_W*i +: PWM_W]
//   gnt        : registered one-hot grant
//   busy       : registered, high while the LED is owned
//   led_r/g/b  : registered active-high LED drive
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int PWM_W    = 8,
    parameter int MAX_HOLD = 16777216
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic [COLOR_W*NREQ-1:0] color,
    input  logic [PWM_W*NREQ-1:0]   duty,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    led_r,
    output logic                    led_g,
    output logic                    led_b
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);
    localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    // Rotate so the slot after 'last' sits at bit 0, take the lowest set bit,
    // then map the position back to a requester index.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        int                start;
        int                enc;
        start = (int'(last) + 32'sd1) % NREQ;
        dbl   = {r, r} >> start;
        rot   = dbl[NREQ-1:0];
        enc   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                enc = k;
            end
        end
        rr_pick = IDX_W'((start + enc) % NREQ);
    endfunction

    arb_state_t          r_state;
    arb_state_t          w_state_nx;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     w_gnt_nx;
    logic                r_busy;
    logic [IDX_W-1:0]    r_last;
    logic [IDX_W-1:0]    w_last_nx;
    logic [CNT_W-1:0]    r_hold;
    logic [CNT_W-1:0]    w_hold_nx;
    logic [IDX_W-1:0]    w_pick;
    logic [NREQ-1:0]     w_owner_oh;
    logic [NREQ-1:0]     w_others;
    logic [COLOR_W-1:0]  w_color;
    logic [PWM_W-1:0]    w_duty;

    assign w_pick     = rr_pick(req, r_last);
    assign w_owner_oh = ONE_HOT0 << r_last;
    assign w_others   = req & ~w_owner_oh;

    // Owner's colour/duty only; forced to zero when idle so unowned inputs cannot leak.
    always_comb begin
        w_color = '0;
        w_duty  = '0;
        if (r_busy) begin
            w_color = color[COLOR_W*r_last +: COLOR_W];
            w_duty  = duty[PWM_W*r_last +: PWM_W];
        end else begin
            w_color = '0;
            w_duty  = '0;
        end
    end

    // Next-state: grant, release (wins over preemption), preemption, saturating hold.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_last_nx  = r_last;
        w_hold_nx  = r_hold;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nx = OWNED;
                    w_last_nx  = w_pick;
                    w_gnt_nx   = ONE_HOT0 << w_pick;
                    w_hold_nx  = '0;
                end else begin
                    w_gnt_nx   = '0;
                end
            end
            OWNED: begin
                if (!req[r_last]) begin
                    w_state_nx = IDLE;
                    w_gnt_nx   = '0;
                end else if ((r_hold == HOLD_MAX) && (|w_others)) begin
                    w_state_nx = IDLE;
                    w_gnt_nx   = '0;
                end else if (r_hold != HOLD_MAX) begin
                    w_hold_nx  = r_hold + 1'b1;
                end else begin
                    w_hold_nx  = r_hold;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    // Arbiter state registers; busy is registered alongside gnt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_last  <= IDX_W'(NREQ - 1);
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_busy  <= (w_state_nx == OWNED);
            r_last  <= w_last_nx;
            r_hold  <= w_hold_nx;
        end
    end

    led_pwm #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk   (clk),
        .rstn  (rstn),
        .en    (r_busy),
        .color (w_color),
        .duty  (w_duty),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b)
    );

    assign gnt  = r_gnt;
    assign busy = r_busy;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed testbench for led_arbiter with MAX_HOLD=16, PWM_W=4, NREQ=4.
module tb_led_arbiter;

    localparam int NREQ     = 4;
    localparam int PWM_W    = 4;
    localparam int MAX_HOLD = 16;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       req;
    logic [3*NREQ-1:0]     color;
    logic [PWM_W*NREQ-1:0] duty;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  led_r;
    logic                  led_g;
    logic                  led_b;

    int n_checks = 0;
    int n_errors = 0;

    led_arbiter #(
        .NREQ     (NREQ),
        .PWM_W    (PWM_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req),
        .color (color),
        .duty  (duty),
        .gnt   (gnt),
        .busy  (busy),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int n, input logic [NREQ-1:0] exp_gnt,
                             output int cr, output int cg, output int cb, output int cgnt);
        cr = 0; cg = 0; cb = 0; cgnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            cr += int'(led_r);
            cg += int'(led_g);
            cb += int'(led_b);
            if (gnt === exp_gnt) cgnt++;
        end
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #3;
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_led"}, 32'({led_r, led_g, led_b}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int cr, cg, cb, cgnt, n;
        logic [NREQ-1:0] e;
        req = '0; color = '0; duty = '0; rstn = 1'b0;

        // 1: single requester, red at duty 8 -> 8 of 16 cycles.
        do_reset("rst0");
        step();
        req = 4'b0001; color[2:0] = 3'b100; duty[3:0] = 4'd8;
        step();
        check("t1_gnt", 32'(gnt), 32'b0001);
        check("t1_busy", 32'(busy), 32'd1);
        run_count(16, 4'b0001, cr, cg, cb, cgnt);
        check("t1_red_on", 32'(cr), 32'd8);
        check("t1_green_on", 32'(cg), 32'd0);
        check("t1_blue_on", 32'(cb), 32'd0);
        check("t1_gnt_held", 32'(cgnt), 32'd16);
        req = 4'b0000;
        step();
        check("t1_rel_gnt", 32'(gnt), 32'd0);
        step();
        check("t1_rel_led", 32'({led_r, led_g, led_b}), 32'd0);

        // 2: all requesting -> rotation 0,1,2,3,0 with 16-cycle holds and 1-cycle gaps.
        do_reset("rst1");
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            check("t2_rot_gnt", 32'(gnt), 32'(e));
            if (k < 4) begin
                n = 0;
                while (gnt === e && n < 40) begin
                    n++;
                    step();
                end
                check("t2_hold_len", 32'(n), 32'd16);
                check("t2_gap", 32'(gnt), 32'd0);
                step();
            end
        end
        req = 4'b0000;

        // 3: owner 2 drops while requester 1 waits.
        do_reset("rst2");
        color[8:6] = 3'b111; duty[11:8] = 4'd15;
        req = 4'b0100;
        step();
        check("t3_gnt2", 32'(gnt), 32'b0100);
        req = 4'b0110;
        step(); step(); step();
        req = 4'b0010;
        step();
        check("t3_gap_gnt", 32'(gnt), 32'd0);
        check("t3_gap_busy", 32'(busy), 32'd0);
        step();
        check("t3_gnt1", 32'(gnt), 32'b0010);
        check("t3_led_off", 32'({led_r, led_g, led_b}), 32'd0);
        req = 4'b0000;

        // 4: lone requester held 100 cycles, duty 0 then 15.
        do_reset("rst3");
        color[2:0] = 3'b111; duty[3:0] = 4'd0;
        req = 4'b0001;
        step();
        check("t4_gnt", 32'(gnt), 32'b0001);
        run_count(100, 4'b0001, cr, cg, cb, cgnt);
        check("t4_no_preempt", 32'(cgnt), 32'd100);
        check("t4_duty0_dark", 32'(cr + cg + cb), 32'd0);
        duty[3:0] = 4'd15;
        run_count(16, 4'b0001, cr, cg, cb, cgnt);
        check("t4_duty15_r", 32'(cr), 32'd15);
        check("t4_duty15_b", 32'(cb), 32'd15);

        // 5: asynchronous reset mid-grant, then requester 3 alone.
        rstn = 1'b0;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_led", 32'({led_r, led_g, led_b}), 32'd0);
        req = 4'b1000; color = '0; duty = '0;
        color[11:9] = 3'b010; duty[15:12] = 4'd2;
        @(negedge clk);
        rstn = 1'b1;
        step(); step();
        check("t5_gnt3", 32'(gnt), 32'b1000);

        // 6: owner fades from duty 2 to 12 while keeping the grant.
        run_count(16, 4'b1000, cr, cg, cb, cgnt);
        check("t6_duty2_g", 32'(cg), 32'd2);
        check("t6_duty2_r", 32'(cr), 32'd0);
        check("t6_gnt_a", 32'(cgnt), 32'd16);
        duty[15:12] = 4'd12;
        run_count(16, 4'b1000, cr, cg, cb, cgnt);
        check("t6_duty12_g", 32'(cg), 32'd12);
        check("t6_gnt_b", 32'(cgnt), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
